if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the byte-wide memory controller.
- Issues four sequential byte-read requests per instruction, captures the bytes returned one cycle after each serviced request, and assembles a little-endian 32-bit instruction.
- Presents the instruction with its PC to the IF/ID register using a valid/stall handshake.
- Handles branch redirects and yields to MEM-stage priority at the memory controller.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall_in  in  1  IF/ID cannot accept; hold the presented instruction.
- branch_flag_in  in  1  redirect request from the execute stage.
- branch_target_in  in  32  new PC for the redirect.
- mem_busy_i  in  1  memory controller is serving the MEM stage this cycle; the IF request is not serviced.
- inst_byte_i  in  8  byte returned by memory one cycle after a serviced request.
- if_req_o  out  1  fetch request to the memory controller (combinational).
- if_addr_o  out  32  byte address of the request (combinational).
- inst_valid_o  out  1  inst_o/inst_pc_o valid (registered).
- inst_o  out  32  assembled instruction (registered).
- inst_pc_o  out  32  PC of inst_o (registered).

Behaviour:
- Internal state:
  - pc[31:0]
  - issue_cnt[2:0], 0..4
  - recv_cnt[2:0], 0..4
  - pending (a request was serviced last cycle)
  - byte buffer buf[0..3]
  - state in {FETCH, DONE}
- Reset: pc=RESET_PC, counters=0, pending=0, state=FETCH, inst_valid_o=0, inst_o=0, inst_pc_o=0. if_req_o=0 during reset cycles.
- Priority each cycle: rst > branch_flag_in > normal operation.
- if_req_o = (state==FETCH) & (issue_cnt<4) & !branch_flag_in & !rst. if_addr_o = pc + issue_cnt, 32-bit wrap.
- Serviced request: if_req_o & !mem_busy_i. On the edge, issue_cnt++ and pending<=1; otherwise pending<=0. An unserviced request is re-driven with the same address next cycle.
- Capture: if pending, buf[recv_cnt]<=inst_byte_i and recv_cnt++. Capture is independent of mem_busy_i in the capture cycle.
- Completion, when the captured byte is byte 3 (recv_cnt==3 & pending):
  - inst_o <= {inst_byte_i, buf[2], buf[1], buf[0]}
  - inst_pc_o <= pc, inst_valid_o <= 1, state <= DONE
- DONE:
  - if_req_o=0; outputs held stable while stall_in=1.
  - When stall_in=0, the instruction is consumed on that edge: inst_valid_o<=0, pc<=pc+4 (wraps 0xFFFF_FFFC -> 0), counters<=0, state<=FETCH.
  - inst_valid_o is high for exactly one cycle per instruction when stall_in=0.
- Latency, no contention: requests serviced at cycles 0,1,2,3; bytes captured at the edges ending cycles 1..4; inst_valid_o=1 in cycle 5. Next instruction's first request is in cycle 6. Steady state is 6 cycles per instruction.
- mem_busy_i contention: each busy cycle in which a request is pending delays completion by one cycle. Byte order and address are unaffected.
- Redirect (branch_flag_in=1 in any state):
  - pc<=branch_target_in, counters<=0, pending<=0, inst_valid_o<=0, state<=FETCH.
  - Any byte returning in the following cycle is discarded.
  - An instruction presented in DONE is dropped even if stall_in=0.
  - Fetch from the target starts the cycle after the redirect.
- branch_target_in is used unmodified; low two bits are not cleared.
- Reset asserted mid-fetch or in DONE: full reset state next cycle; in-flight byte discarded.
- stall_in is ignored in FETCH.

Test Plan:
- Reset then fetch: RESET_PC=0, memory[0..3]=13,05,A0,00, mem_busy_i=0, stall_in=0 -> if_addr_o 0,1,2,3 in cycles 0-3; inst_valid_o=1 in cycle 5 with inst_o=32'h00A00513, inst_pc_o=0; next request addr 4 in cycle 6.
- Contention: mem_busy_i=1 in cycles 1-2 during the first fetch -> addr 1 held for 3 cycles; inst_o still 32'h00A00513, valid in cycle 7.
- Stall hold: stall_in=1 for 4 cycles after valid -> inst_valid_o/inst_o/inst_pc_o stable, if_req_o=0; stall release -> pc advances to 4 exactly once.
- Redirect mid-fetch: branch_flag_in=1, target=32'h100 in cycle 2 -> if_req_o=0 that cycle; cycle 3 if_addr_o=0x100; old byte discarded; result inst_pc_o=0x100 with bytes from 0x100..0x103.
- Redirect in DONE with stall_in=0, target=0x40 -> no valid pulse for the old instruction; next valid has inst_pc_o=0x40.
- Wrap / reset mid-operation: pc=0xFFFF_FFFC completes -> next fetch addr 0. rst pulsed at cycle 3 of a fetch -> if_addr_o=RESET_PC after release, inst_valid_o=0.

Source files
------------

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch stage in front of a byte-wide memory
// controller. Issues four sequential byte reads per instruction, captures each
// returned byte one cycle after its request was serviced, assembles a
// little-endian 32-bit word and presents it to IF/ID with a valid/stall
// handshake. Branch redirects abort the current fetch; MEM-stage traffic
// (mem_busy_i) delays request issue without disturbing byte order.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   stall_in             IF/ID cannot accept; hold the presented instruction
//   branch_flag_in       redirect request from execute
//   branch_target_in     redirect PC (used unmodified)
//   mem_busy_i           memory controller busy with MEM stage this cycle
//   inst_byte_i          byte returned one cycle after a serviced request
//   if_req_o, if_addr_o  combinational fetch request / byte address
//   inst_valid_o         registered valid for inst_o / inst_pc_o
//   inst_o, inst_pc_o    registered instruction and its PC
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        branch_flag_in,
  input  logic [31:0] branch_target_in,
  input  logic        mem_busy_i,
  input  logic [7:0]  inst_byte_i,
  output logic        if_req_o,
  output logic [31:0] if_addr_o,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o
);

  typedef enum logic {FETCH, DONE} state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [2:0]        issue_cnt_q, issue_cnt_d;
  logic [2:0]        recv_cnt_q, recv_cnt_d;
  logic              byte_vld_p1_q, byte_vld_p1_d;
  logic [2:0][7:0]   byte_buf_q, byte_buf_d;
  logic              inst_valid_q, inst_valid_d;
  logic [31:0]       inst_q, inst_d;
  logic [31:0]       inst_pc_q, inst_pc_d;
  logic              serviced;

  // Request stage: address issue towards the memory controller
  assign if_req_o  = (state_q == FETCH) && (issue_cnt_q < 3'd4) && !branch_flag_in && !rst;
  assign if_addr_o = pc_q + {29'd0, issue_cnt_q};
  assign serviced  = if_req_o && !mem_busy_i;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    issue_cnt_d   = issue_cnt_q;
    recv_cnt_d    = recv_cnt_q;
    byte_vld_p1_d = 1'b0;
    byte_buf_d    = byte_buf_q;
    inst_valid_d  = inst_valid_q;
    inst_d        = inst_q;
    inst_pc_d     = inst_pc_q;

    if (branch_flag_in) begin
      pc_d         = branch_target_in;
      issue_cnt_d  = 3'd0;
      recv_cnt_d   = 3'd0;
      inst_valid_d = 1'b0;
      state_d      = FETCH;
    end else begin
      byte_vld_p1_d = serviced;
      if (serviced) begin
        issue_cnt_d = issue_cnt_q + 3'd1;
      end

      // Capture stage: byte returned for the request serviced last cycle
      if (byte_vld_p1_q) begin
        recv_cnt_d = recv_cnt_q + 3'd1;
        case (recv_cnt_q)
          3'd0: byte_buf_d[0] = inst_byte_i;
          3'd1: byte_buf_d[1] = inst_byte_i;
          3'd2: byte_buf_d[2] = inst_byte_i;
          3'd3: begin
            inst_d       = {inst_byte_i, byte_buf_q[2], byte_buf_q[1], byte_buf_q[0]};
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            state_d      = DONE;
          end
          default: ;
        endcase
      end

      // Present stage: handshake with IF/ID
      if (state_q == DONE && !stall_in) begin
        inst_valid_d = 1'b0;
        pc_d         = pc_q + 32'd4;
        issue_cnt_d  = 3'd0;
        recv_cnt_d   = 3'd0;
        state_d      = FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    byte_buf_q <= byte_buf_d;
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      issue_cnt_q   <= 3'd0;
      recv_cnt_q    <= 3'd0;
      byte_vld_p1_q <= 1'b0;
      inst_valid_q  <= 1'b0;
      inst_q        <= 32'd0;
      inst_pc_q     <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      issue_cnt_q   <= issue_cnt_d;
      recv_cnt_q    <= recv_cnt_d;
      byte_vld_p1_q <= byte_vld_p1_d;
      inst_valid_q  <= inst_valid_d;
      inst_q        <= inst_d;
      inst_pc_q     <= inst_pc_d;
    end
  end

  assign inst_valid_o = inst_valid_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: byte memory responder, transaction-level
// reference model checked every cycle, and directed scenarios with literal
// expected values.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_in = 1'b0;
  logic        branch_flag_in = 1'b0;
  logic [31:0] branch_target_in = 32'd0;
  logic        mem_busy_i = 1'b0;
  logic [7:0]  inst_byte_i;
  logic        if_req_o;
  logic [31:0] if_addr_o;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall_in         (stall_in),
    .branch_flag_in   (branch_flag_in),
    .branch_target_in (branch_target_in),
    .mem_busy_i       (mem_busy_i),
    .inst_byte_i      (inst_byte_i),
    .if_req_o         (if_req_o),
    .if_addr_o        (if_addr_o),
    .inst_valid_o     (inst_valid_o),
    .inst_o           (inst_o),
    .inst_pc_o        (inst_pc_o)
  );

  // Memory contents: addresses 0..3 hold 13 05 A0 00, everything else a
  // simple address hash.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h05;
      32'd2:   return 8'hA0;
      32'd3:   return 8'h00;
      default: return a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  // Byte responder: data one cycle after a serviced request, junk otherwise.
  logic [7:0] rdata;
  always @(posedge clk) begin
    rdata <= (if_req_o && !mem_busy_i) ? mem_byte(if_addr_o) : 8'hEE;
  end
  assign inst_byte_i = rdata;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: tracks which instruction is being fetched, how many of
  // its four byte requests have been accepted, and whether an instruction is
  // being presented. The instruction word comes straight from memory.
  logic [31:0] m_pc, m_inst, m_ipc;
  int          m_srv;
  bit          m_valid;
  bit          m_known = 1'b0;
  bit          exp_req;

  initial begin
    m_pc = 0; m_inst = 0; m_ipc = 0; m_srv = 0; m_valid = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_pc = 32'h0; m_srv = 0; m_valid = 0; m_inst = 0; m_ipc = 0; m_known = 1'b1;
      end else if (branch_flag_in) begin
        m_pc = branch_target_in; m_srv = 0; m_valid = 0;
      end else if (m_valid) begin
        if (!stall_in) begin
          m_valid = 0; m_pc = m_pc + 32'd4; m_srv = 0;
        end
      end else if (m_srv == 4) begin
        m_valid = 1;
        m_ipc   = m_pc;
        m_inst  = {mem_byte(m_pc + 32'd3), mem_byte(m_pc + 32'd2),
                   mem_byte(m_pc + 32'd1), mem_byte(m_pc)};
      end else if (!mem_busy_i) begin
        m_srv++;
      end
      @(negedge clk);
      if (m_known) begin
        exp_req = !rst && !branch_flag_in && !m_valid && (m_srv < 4);
        chk("model_req", {31'd0, if_req_o}, {31'd0, exp_req});
        if (exp_req) chk("model_addr", if_addr_o, m_pc + 32'(m_srv));
        chk("model_valid", {31'd0, inst_valid_o}, {31'd0, m_valid});
        chk("model_inst", inst_o, m_inst);
        chk("model_pc", inst_pc_o, m_ipc);
      end
    end
  end

  // One cycle: drive inputs just after the edge, return just after the
  // following falling edge so the outputs can be sampled.
  task automatic cyc(input logic r, input logic b, input logic [31:0] t,
                     input logic busy, input logic st);
    @(posedge clk);
    #1;
    rst = r; branch_flag_in = b; branch_target_in = t;
    mem_busy_i = busy; stall_in = st;
    #5;
  endtask

  task automatic exp_fetch(input string name, input logic [31:0] addr);
    chk({name, "_req"}, {31'd0, if_req_o}, 32'd1);
    chk({name, "_addr"}, if_addr_o, addr);
  endtask

  task automatic exp_idle(input string name);
    chk({name, "_req"}, {31'd0, if_req_o}, 32'd0);
  endtask

  task automatic exp_out(input string name, input logic v,
                         input logic [31:0] inst, input logic [31:0] pc);
    chk({name, "_valid"}, {31'd0, inst_valid_o}, {31'd0, v});
    if (v) begin
      chk({name, "_inst"}, inst_o, inst);
      chk({name, "_pc"}, inst_pc_o, pc);
    end
  endtask

  initial begin
    // Reset state
    cyc(1, 0, 0, 0, 0);
    exp_idle("rst");
    chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_pc", inst_pc_o, 32'd0);

    // Uncontended fetch from RESET_PC
    cyc(0, 0, 0, 0, 0); exp_fetch("a0", 32'd0);
    cyc(0, 0, 0, 0, 0); exp_fetch("a1", 32'd1);
    cyc(0, 0, 0, 0, 0); exp_fetch("a2", 32'd2);
    cyc(0, 0, 0, 0, 0); exp_fetch("a3", 32'd3);
    cyc(0, 0, 0, 0, 0); exp_idle("a4"); exp_out("a4", 0, 0, 0);
    cyc(0, 0, 0, 0, 0); exp_idle("a5"); exp_out("a5", 1, 32'h00A00513, 32'h0);
    cyc(0, 0, 0, 0, 0); exp_fetch("a6", 32'd4); exp_out("a6", 0, 0, 0);
    cyc(1, 0, 0, 0, 0); exp_idle("a7_rst");

    // Contention on the second request, then stall hold
    cyc(0, 0, 0, 0, 0); exp_fetch("b0", 32'd0);
    chk("b0_inst_cleared", inst_o, 32'd0);
    cyc(0, 0, 0, 1, 0); exp_fetch("b1", 32'd1);
    cyc(0, 0, 0, 1, 0); exp_fetch("b2", 32'd1);
    cyc(0, 0, 0, 0, 0); exp_fetch("b3", 32'd1);
    cyc(0, 0, 0, 0, 0); exp_fetch("b4", 32'd2);
    cyc(0, 0, 0, 0, 0); exp_fetch("b5", 32'd3);
    cyc(0, 0, 0, 0, 0); exp_idle("b6"); exp_out("b6", 0, 0, 0);
    for (int i = 7; i <= 10; i++) begin
      cyc(0, 0, 0, 0, 1); exp_idle("b_stall"); exp_out("b_stall", 1, 32'h00A00513, 32'h0);
    end
    cyc(0, 0, 0, 0, 0); exp_idle("b11"); exp_out("b11", 1, 32'h00A00513, 32'h0);
    cyc(0, 0, 0, 0, 0); exp_fetch("b12", 32'd4); exp_out("b12", 0, 0, 0);
    cyc(0, 0, 0, 0, 0); exp_fetch("b13", 32'd5);

    // Redirect mid-fetch to 0x100
    cyc(0, 1, 32'h100, 0, 0); exp_idle("c0_br");
    cyc(0, 0, 0, 0, 0); exp_fetch("c1", 32'h100);
    cyc(0, 0, 0, 0, 0); exp_fetch("c2", 32'h101);
    cyc(0, 0, 0, 0, 0); exp_fetch("c3", 32'h102);
    cyc(0, 0, 0, 0, 0); exp_fetch("c4", 32'h103);
    cyc(0, 0, 0, 0, 0); exp_idle("c5");
    cyc(0, 0, 0, 0, 1); exp_out("c6", 1, 32'h58595A5B, 32'h100);

    // Redirect while presenting with stall released: old word dropped
    cyc(0, 1, 32'h40, 0, 0); exp_idle("c7_br"); exp_out("c7", 1, 32'h58595A5B, 32'h100);
    cyc(0, 0, 0, 0, 0); exp_fetch("c8", 32'h40); exp_out("c8", 0, 0, 0);
    cyc(0, 0, 0, 0, 0); exp_fetch("c9", 32'h41);
    cyc(0, 0, 0, 0, 0); exp_fetch("c10", 32'h42);
    cyc(0, 0, 0, 0, 0); exp_fetch("c11", 32'h43);
    cyc(0, 0, 0, 0, 0); exp_out("c12", 0, 0, 0);
    cyc(0, 0, 0, 0, 0); exp_out("c13", 1, 32'h19181B1A, 32'h40);

    // PC wrap at the top of the address space
    cyc(0, 1, 32'hFFFF_FFFC, 0, 0); exp_idle("d0_br");
    cyc(0, 0, 0, 0, 0); exp_fetch("d1", 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0); exp_fetch("d2", 32'hFFFF_FFFD);
    cyc(0, 0, 0, 0, 0); exp_fetch("d3", 32'hFFFF_FFFE);
    cyc(0, 0, 0, 0, 0); exp_fetch("d4", 32'hFFFF_FFFF);
    cyc(0, 0, 0, 0, 0); exp_idle("d5");
    cyc(0, 0, 0, 0, 0); exp_out("d6", 1, 32'h5A5B5859, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0); exp_fetch("d7_wrap", 32'd0);
    cyc(0, 0, 0, 0, 0); exp_fetch("d8", 32'd1);
    cyc(0, 0, 0, 0, 0); exp_fetch("d9", 32'd2);

    // Reset in the fourth request cycle
    cyc(1, 0, 0, 0, 0); exp_idle("d10_rst");
    cyc(0, 0, 0, 0, 0); exp_fetch("d11", 32'd0); exp_out("d11", 0, 0, 0);
    chk("d11_inst_cleared", inst_o, 32'd0);

    // Unaligned redirect target is used as-is
    cyc(0, 1, 32'h102, 0, 0); exp_idle("d12_br");
    cyc(0, 0, 0, 0, 0); exp_fetch("d13", 32'h102);
    cyc(0, 0, 0, 0, 0); exp_fetch("d14", 32'h103);
    cyc(0, 0, 0, 0, 0); exp_fetch("d15", 32'h104);
    cyc(0, 0, 0, 0, 0); exp_fetch("d16", 32'h105);
    cyc(0, 0, 0, 0, 0); exp_idle("d17");
    cyc(0, 0, 0, 0, 0); exp_out("d18", 1, 32'h5E5F5859, 32'h102);

    // Mixed traffic checked by the reference model only
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0), $urandom,
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0));
    end
    cyc(0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
